// File: rtl/hazard_pkg.sv
// Shared types and constants for the GRF hazard controller.
//   TUSE_* / TNEW_* : operand-use and result-ready timing codes
//   fwd_sel_e       : forwarding mux select encodings
//   stage_rec_t     : in-flight destination record {dst, tnew}
package hazard_pkg;

  localparam int unsigned REG_W    = 5;
  localparam int unsigned TIME_W   = 2;
  localparam int unsigned MD_CNT_W = 4;

  localparam logic [TIME_W-1:0] TUSE_D    = 2'd0;
  localparam logic [TIME_W-1:0] TUSE_E    = 2'd1;
  localparam logic [TIME_W-1:0] TUSE_NONE = 2'd3;

  localparam logic [TIME_W-1:0] TNEW_0   = 2'd0;
  localparam logic [TIME_W-1:0] TNEW_1   = 2'd1;
  localparam logic [TIME_W-1:0] TNEW_MAX = 2'd2;

  typedef enum logic [1:0] {
    FWD_GRF = 2'd0,
    FWD_E   = 2'd1,
    FWD_M   = 2'd2,
    FWD_W   = 2'd3
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_W-1:0]  dst;
    logic [TIME_W-1:0] tnew;
  } stage_rec_t;

  // A result can never take longer than two stages past E.
  function automatic logic [TIME_W-1:0] sat_tnew(input logic [TIME_W-1:0] t);
    return (t > TNEW_MAX) ? TNEW_MAX : t;
  endfunction

  function automatic logic [TIME_W-1:0] dec_tnew(input logic [TIME_W-1:0] t);
    return (t == TNEW_0) ? TNEW_0 : t - TIME_W'(1);
  endfunction

  // RAW stall for one source operand against the E and M records.
  function automatic logic op_stall(input logic [REG_W-1:0]  r,
                                    input logic [TIME_W-1:0] tuse,
                                    input stage_rec_t        e,
                                    input stage_rec_t        m);
    logic hit;
    hit = 1'b0;
    if (r != '0 && tuse != TUSE_NONE) begin
      if (e.dst == r && e.tnew > tuse) hit = 1'b1;
      if (m.dst == r && m.tnew > tuse) hit = 1'b1;
    end
    return hit;
  endfunction

  // Youngest matching stage wins; a not-yet-ready match selects GRF and
  // relies on the stall term instead of falling back to an older stage.
  function automatic fwd_sel_e op_fwd(input logic [REG_W-1:0] r,
                                      input stage_rec_t       e,
                                      input stage_rec_t       m,
                                      input stage_rec_t       w);
    fwd_sel_e sel;
    sel = FWD_GRF;
    if (r != '0) begin
      if (e.dst == r)      sel = (e.tnew == TNEW_0) ? FWD_E : FWD_GRF;
      else if (m.dst == r) sel = (m.tnew == TNEW_0) ? FWD_M : FWD_GRF;
      else if (w.dst == r) sel = (w.tnew == TNEW_0) ? FWD_W : FWD_GRF;
    end
    return sel;
  endfunction

endpackage

// File: rtl/grf_hazard_ctrl_md_busy_timer.sv
// Busy window of the multi-cycle mult/div unit.
//   clk, reset : pipeline clock, synchronous active-high reset
//   start      : a mult/div was accepted out of D this cycle
//   is_div     : the accepted operation is a divide
//   md_busy    : unit busy (includes the cycle the op sits in E)
module md_busy_timer
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic md_busy
);

  logic [MD_CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic                e_md_start_q, e_md_start_d;
  logic                e_md_div_q, e_md_div_d;

  // Counter loads the cycle after the op enters E, then runs down to zero.
  always_comb begin
    e_md_start_d = start;
    e_md_div_d   = start & is_div;
    md_cnt_d     = md_cnt_q;
    if (e_md_start_q) begin
      md_cnt_d = e_md_div_q ? MD_CNT_W'(DIV_CYCLES) : MD_CNT_W'(MULT_CYCLES);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - MD_CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      md_cnt_q     <= '0;
      e_md_start_q <= 1'b0;
      e_md_div_q   <= 1'b0;
    end else begin
      md_cnt_q     <= md_cnt_d;
      e_md_start_q <= e_md_start_d;
      e_md_div_q   <= e_md_div_d;
    end
  end

  assign md_busy = (md_cnt_q != '0) || e_md_start_q;

endmodule

// File: rtl/grf_hazard_ctrl.sv
// Register-file hazard scoreboard for the D/E/M/W pipeline.
// Tracks E/M/W destination records, produces the D-stage stall and rs/rt
// forwarding selects, drives the GRF write port from W, and stalls HI/LO
// users while the mult/div unit is busy.
//   Inputs : clk, reset (sync, active high), d_* decode-stage descriptors
//   Outputs: stall, fwd_rs_sel, fwd_rt_sel, grf_we, grf_a3, md_busy, stall_cnt
// Optional: define HAZARD_STATS_EN to build the 32-bit stall-cycle counter;
// otherwise stall_cnt is tied to 0.
module grf_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_W-1:0]  d_rs,
  input  logic [REG_W-1:0]  d_rt,
  input  logic [TIME_W-1:0] d_tuse_rs,
  input  logic [TIME_W-1:0] d_tuse_rt,
  input  logic [REG_W-1:0]  d_dst,
  input  logic [TIME_W-1:0] d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_is_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic              grf_we,
  output logic [REG_W-1:0]  grf_a3,
  output logic              md_busy,
  output logic [31:0]       stall_cnt
);

  stage_rec_t e_q, e_d;
  stage_rec_t m_q, m_d;
  stage_rec_t w_q, w_d;

  logic     md_busy_raw;
  logic     md_accept;
  fwd_sel_e rs_sel, rt_sel;

  md_busy_timer #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES)
  ) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .start   (md_accept),
    .is_div  (d_md_is_div),
    .md_busy (md_busy_raw)
  );

  // Hazard detection, forwarding and pipeline advance. Outputs are forced
  // quiet while reset is held so the reset cycle itself presents no stall.
  always_comb begin
    stall = !reset && d_valid &&
            (op_stall(d_rs, d_tuse_rs, e_q, m_q) ||
             op_stall(d_rt, d_tuse_rt, e_q, m_q) ||
             (d_md_use && md_busy_raw));

    rs_sel     = reset ? FWD_GRF : op_fwd(d_rs, e_q, m_q, w_q);
    rt_sel     = reset ? FWD_GRF : op_fwd(d_rt, e_q, m_q, w_q);
    fwd_rs_sel = 2'(rs_sel);
    fwd_rt_sel = 2'(rt_sel);

    grf_a3  = w_q.dst;
    grf_we  = !reset && (w_q.dst != '0);
    md_busy = !reset && md_busy_raw;

    e_d = '0;
    if (d_valid && !stall) begin
      e_d.dst  = d_dst;
      e_d.tnew = sat_tnew(d_tnew);
    end
    m_d.dst  = e_q.dst;
    m_d.tnew = dec_tnew(e_q.tnew);
    w_d.dst  = m_q.dst;
    w_d.tnew = TNEW_0;
  end

  // A start held in D by a stall is only taken once D advances.
  assign md_accept = d_valid && d_md_start && !stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= e_d;
      m_q <= m_d;
      w_q <= w_d;
    end
  end

`ifdef HAZARD_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall ? stall_cnt_q + 32'd1 : stall_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (reset) stall_cnt_q <= '0;
    else       stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_grf_hazard_ctrl.sv
// Scoreboard bench for grf_hazard_ctrl: the driver pushes hand-computed
// expectations per cycle, a negedge monitor pops and compares.
module tb_grf_hazard_ctrl;

  logic        clk;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs, d_rt, d_dst;
  logic [1:0]  d_tuse_rs, d_tuse_rt, d_tnew;
  logic        d_md_start, d_md_is_div, d_md_use;
  logic        stall;
  logic [1:0]  fwd_rs_sel, fwd_rt_sel;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic        md_busy;
  logic [31:0] stall_cnt;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  typedef struct {
    int          id;
    logic        st;
    logic [1:0]  frs;
    logic [1:0]  frt;
    logic        we;
    logic [4:0]  a3;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          vec_id = 0;
  logic [31:0] exp_scnt = '0;

  grf_hazard_ctrl #(
    .MULT_CYCLES (5),
    .DIV_CYCLES  (10)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .d_valid     (d_valid),
    .d_rs        (d_rs),
    .d_rt        (d_rt),
    .d_tuse_rs   (d_tuse_rs),
    .d_tuse_rt   (d_tuse_rt),
    .d_dst       (d_dst),
    .d_tnew      (d_tnew),
    .d_md_start  (d_md_start),
    .d_md_is_div (d_md_is_div),
    .d_md_use    (d_md_use),
    .stall       (stall),
    .fwd_rs_sel  (fwd_rs_sel),
    .fwd_rt_sel  (fwd_rt_sel),
    .grf_we      (grf_we),
    .grf_a3      (grf_a3),
    .md_busy     (md_busy),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input int id,
                       input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL vec%0d %s: got %0d expected %0d", id, nm, act, req);
    end
  endtask

  // Monitor: DUT presents outputs every cycle; compare mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("stall",      e.id, 32'(stall),      32'(e.st));
      check("fwd_rs_sel", e.id, 32'(fwd_rs_sel), 32'(e.frs));
      check("fwd_rt_sel", e.id, 32'(fwd_rt_sel), 32'(e.frt));
      check("grf_we",     e.id, 32'(grf_we),     32'(e.we));
      check("grf_a3",     e.id, 32'(grf_a3),     32'(e.a3));
      check("md_busy",    e.id, 32'(md_busy),    32'(e.busy));
      check("stall_cnt",  e.id, stall_cnt,       e.cnt);
    end
  end

  // One pipeline cycle: drive D-stage inputs, push the expected outputs.
  task automatic cyc(input logic rst, input logic v,
                     input logic [4:0] rs, input logic [4:0] rt,
                     input logic [1:0] urs, input logic [1:0] urt,
                     input logic [4:0] dst, input logic [1:0] tn,
                     input logic mds, input logic mdd, input logic mdu,
                     input logic est, input logic [1:0] efrs, input logic [1:0] efrt,
                     input logic ewe, input logic [4:0] ea3, input logic ebusy);
    exp_t e;
    @(posedge clk);
    #1;
    reset = rst; d_valid = v; d_rs = rs; d_rt = rt;
    d_tuse_rs = urs; d_tuse_rt = urt; d_dst = dst; d_tnew = tn;
    d_md_start = mds; d_md_is_div = mdd; d_md_use = mdu;
    e.id = vec_id; e.st = est; e.frs = efrs; e.frt = efrt;
    e.we = ewe; e.a3 = ea3; e.busy = ebusy;
    e.cnt = STATS ? exp_scnt : 32'd0;
    exp_q.push_back(e);
    vec_id++;
    if (rst) exp_scnt = '0;
    else     exp_scnt = exp_scnt + 32'(est);
  endtask

  task automatic idle(input logic ewe, input logic [4:0] ea3, input logic ebusy);
    cyc(0, 0, 5'd0, 5'd0, 2'd3, 2'd3, 5'd0, 2'd0, 0, 0, 0,
        0, 2'd0, 2'd0, ewe, ea3, ebusy);
  endtask

  initial begin
    reset = 1'b1; d_valid = 1'b0; d_rs = '0; d_rt = '0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_dst = '0; d_tnew = '0;
    d_md_start = 1'b0; d_md_is_div = 1'b0; d_md_use = 1'b0;

    // Reset state
    cyc(1,0, 0, 0,3,3, 0,0, 0,0,0,  0,0,0, 0, 0,0);

    // lw $3 (tnew 2) then beq on $3 (tuse 0): two stalls, then forward from W
    cyc(0,1, 0, 0,3,3, 3,2, 0,0,0,  0,0,0, 0, 0,0);
    cyc(0,1, 3, 4,0,0, 0,0, 0,0,0,  1,0,0, 0, 0,0);
    cyc(0,1, 3, 4,0,0, 0,0, 0,0,0,  1,0,0, 0, 0,0);
    cyc(0,1, 3, 4,0,0, 0,0, 0,0,0,  0,3,0, 1, 3,0);
    idle(0, 0, 0);

    // addu chain with tuse 1: no stall, forward from M then M/W
    cyc(0,1, 1, 2,1,1, 5,1, 0,0,0,  0,0,0, 0, 0,0);
    cyc(0,1, 5, 6,1,1, 7,1, 0,0,0,  0,0,0, 0, 0,0);
    cyc(0,1, 5, 7,1,1, 0,0, 0,0,0,  0,2,0, 0, 0,0);
    cyc(0,1, 7, 5,0,0, 0,0, 0,0,0,  0,2,3, 1, 5,0);
    idle(1, 7, 0);

    // Write to $0 then read $0: no stall, no forward, no GRF write
    cyc(0,1, 0, 0,3,3, 0,2, 0,0,0,  0,0,0, 0, 0,0);
    cyc(0,1, 0, 0,0,0, 0,0, 0,0,0,  0,0,0, 0, 0,0);
    idle(0, 0, 0);
    idle(0, 0, 0);

    // div then mflo: DIV_CYCLES+1 stall cycles
    cyc(0,1, 8, 9,1,1, 0,0, 1,1,1,  0,0,0, 0, 0,0);
    for (int i = 0; i < 11; i++)
      cyc(0,1, 0, 0,3,3, 10,1, 0,0,1,  1,0,0, 0, 0,1);
    cyc(0,1, 0, 0,3,3, 10,1, 0,0,1,  0,0,0, 0, 0,0);
    idle(0, 0, 0);
    idle(0, 0, 0);
    idle(1, 10, 0);

    // Reset with live E/M/W records and md_cnt=7
    cyc(0,1, 0, 0,3,3, 11,1, 0,0,0,  0,0,0, 0, 0,0);
    cyc(0,1, 0, 0,3,3, 0,0,  1,1,1,  0,0,0, 0, 0,0);
    cyc(0,1, 0, 0,3,3, 12,2, 0,0,0,  0,0,0, 0, 0,1);
    cyc(0,1, 0, 0,3,3, 13,1, 0,0,0,  0,0,0, 1,11,1);
    cyc(0,1, 0, 0,3,3, 14,0, 0,0,0,  0,0,0, 0, 0,1);
    cyc(0,1, 0, 0,3,3, 15,1, 0,0,0,  0,0,0, 1,12,1);
    cyc(1,1,15,14,0,0, 0,0,  0,0,1,  0,0,0, 0,13,0);
    cyc(0,1,15,14,0,0, 0,0,  0,0,1,  0,0,0, 0, 0,0);

    // Three load-use stalls; first load uses tnew=3 (saturates to 2)
    cyc(0,1, 0, 0,3,3, 3,3, 0,0,0,  0,0,0, 0, 0,0);
    cyc(0,1, 3, 0,1,1, 4,1, 0,0,0,  1,0,0, 0, 0,0);
    cyc(0,1, 3, 0,1,1, 4,1, 0,0,0,  0,0,0, 0, 0,0);
    cyc(0,1, 0, 0,3,3, 5,2, 0,0,0,  0,0,0, 1, 3,0);
    cyc(0,1, 5, 4,1,1, 6,1, 0,0,0,  1,0,2, 0, 0,0);
    cyc(0,1, 5, 4,1,1, 6,1, 0,0,0,  0,0,3, 1, 4,0);
    cyc(0,1, 0, 0,3,3, 7,2, 0,0,0,  0,0,0, 1, 5,0);
    cyc(0,1, 7, 6,1,1, 0,0, 0,0,0,  1,0,2, 0, 0,0);
    cyc(0,1, 7, 6,1,1, 0,0, 0,0,0,  0,0,3, 1, 6,0);
    idle(1, 7, 0);
    idle(0, 0, 0);

    // mult then mfhi: MULT_CYCLES+1 stall cycles
    cyc(0,1, 0, 0,3,3, 0,0, 1,0,1,  0,0,0, 0, 0,0);
    for (int i = 0; i < 6; i++)
      cyc(0,1, 0, 0,3,3, 8,1, 0,0,1,  1,0,0, 0, 0,1);
    cyc(0,1, 0, 0,3,3, 8,1, 0,0,1,  0,0,0, 0, 0,0);
    idle(0, 0, 0);
    idle(0, 0, 0);
    idle(1, 8, 0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required finish before 100000");
    $fatal(1, "watchdog");
  end

endmodule
